// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Sequential ALU with a valid/ready handshake on both sides.
//               Most operations finish one cycle after capture. Multiply
//               (shift-add) and divide (restoring) take WIDTH iterations,
//               one bit per cycle. The result is held in DONE until the
//               consumer accepts it.
// Options     : ALU_SEQ_FLAGS_EN - when defined, registers {zero, neg,
//               carry, ovf} alongside the result. When undefined, flags
//               is tied to zero and no flag logic exists.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       flags
);

  localparam int                c_SHW  = $clog2(WIDTH);
  localparam int                c_CNTW = $clog2(WIDTH);
  localparam logic [c_CNTW-1:0] c_LAST = c_CNTW'(WIDTH - 1);

  localparam logic [1:0] c_IDLE = 2'b00;
  localparam logic [1:0] c_BUSY = 2'b01;
  localparam logic [1:0] c_DONE = 2'b10;

  localparam logic [3:0] c_OP_MUL = 4'd2;
  localparam logic [3:0] c_OP_DIV = 4'd3;

  logic [1:0]        r_state;
  logic [c_CNTW-1:0] r_cnt;
  logic [WIDTH-1:0]  r_a;     // multiplicand (mul) or quotient shifter (div)
  logic [WIDTH-1:0]  r_b;     // multiplier (mul) or divisor (div)
  logic [WIDTH-1:0]  r_acc;   // partial product (mul) or remainder (div)
  logic [3:0]        r_op;
  logic [WIDTH-1:0]  r_out;

  logic              w_idle;
  logic              w_accept;
  logic              w_is_iter;
  logic              w_iter_last;
  logic [c_SHW-1:0]  w_shamt;
  logic [WIDTH-1:0]  w_pop;
  logic [WIDTH-1:0]  w_alu;
  logic [WIDTH-1:0]  w_mul_acc;
  logic [WIDTH:0]    w_rem_sh;
  logic [WIDTH:0]    w_diff;
  logic [WIDTH-1:0]  w_div_rem;
  logic [WIDTH-1:0]  w_div_q;
  logic [WIDTH-1:0]  w_iter_res;

  // The unused fourth encoding behaves as IDLE, so only BUSY/DONE block input
  assign w_idle      = (r_state != c_BUSY) && (r_state != c_DONE);
  assign w_accept    = w_idle && in_valid;
  assign w_is_iter   = (op == c_OP_MUL) || (op == c_OP_DIV);
  assign w_iter_last = (r_state == c_BUSY) && (r_cnt == c_LAST);
  assign w_shamt     = b[c_SHW-1:0];

  assign in_ready  = w_idle;
  assign out_valid = (r_state == c_DONE);
  assign out       = r_out;

  // One shift-add step: add the multiplicand when the current multiplier bit is set
  assign w_mul_acc = r_b[0] ? (r_acc + r_a) : r_acc;

  // One restoring-division step. A zero divisor always "fits", giving all-ones
  assign w_rem_sh   = {r_acc, r_a[WIDTH-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_b};
  assign w_div_rem  = w_diff[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_div_q    = {r_a[WIDTH-2:0], ~w_diff[WIDTH]};
  assign w_iter_res = (r_op == c_OP_DIV) ? w_div_q : w_mul_acc;

  // Single-cycle datapath, evaluated directly on the request inputs
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + {{(WIDTH-1){1'b0}}, a[i]};
    end
    w_alu = '0;
    case (op)
      4'd0:    w_alu = a + b;
      4'd1:    w_alu = a - b;
      4'd4:    w_alu = a & b;
      4'd5:    w_alu = a | b;
      4'd6:    w_alu = a ^ b;
      4'd7:    w_alu = ~a;
      4'd8:    w_alu = a;
      4'd9:    w_alu = b;
      4'd10:   w_alu = a << w_shamt;
      4'd11:   w_alu = a >> w_shamt;
      4'd12:   w_alu = $unsigned($signed(a) >>> w_shamt);
      4'd13:   w_alu = a + WIDTH'(4);
      4'd14:   w_alu = a - WIDTH'(4);
      4'd15:   w_alu = w_pop;
      default: w_alu = '0;  // mul/div produced by the iterative path
    endcase
  end

  // Control FSM plus operand/iteration registers and the result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_op    <= '0;
      r_out   <= '0;
    end else begin
      case (r_state)
        c_BUSY: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_op == c_OP_DIV) begin
            r_acc <= w_div_rem;
            r_a   <= w_div_q;
          end else begin
            r_acc <= w_mul_acc;
            r_a   <= {r_a[WIDTH-2:0], 1'b0};
            r_b   <= {1'b0, r_b[WIDTH-1:1]};
          end
          if (r_cnt == c_LAST) begin
            r_state <= c_DONE;
            r_out   <= w_iter_res;
          end
        end
        c_DONE: begin
          if (out_ready) begin
            r_state <= c_IDLE;
          end
        end
        default: begin
          if (in_valid) begin
            r_a   <= a;
            r_b   <= b;
            r_op  <= op;
            r_acc <= '0;
            r_cnt <= '0;
            if (w_is_iter) begin
              r_state <= c_BUSY;
            end else begin
              r_state <= c_DONE;
              r_out   <= w_alu;
            end
          end
        end
      endcase
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic       w_cry;
  logic       w_ovf;
  logic [3:0] w_flags_alu;
  logic [3:0] w_flags_iter;
  logic [3:0] r_flags;

  // Carry/borrow and signed overflow exist only for the add/sub family
  always_comb begin
    w_cry = 1'b0;
    w_ovf = 1'b0;
    case (op)
      4'd0: begin
        w_cry = (w_alu < a);
        w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_alu[WIDTH-1] != a[WIDTH-1]);
      end
      4'd1: begin
        w_cry = (a < b);
        w_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_alu[WIDTH-1] != a[WIDTH-1]);
      end
      4'd13: begin
        w_cry = (w_alu < a);
        w_ovf = ~a[WIDTH-1] & w_alu[WIDTH-1];
      end
      4'd14: begin
        w_cry = (a < WIDTH'(4));
        w_ovf = a[WIDTH-1] & ~w_alu[WIDTH-1];
      end
      default: begin
        w_cry = 1'b0;
        w_ovf = 1'b0;
      end
    endcase
  end

  assign w_flags_alu  = {(w_alu == '0), w_alu[WIDTH-1], w_cry, w_ovf};
  assign w_flags_iter = {(w_iter_res == '0), w_iter_res[WIDTH-1], 2'b00};

  // Flags are loaded on exactly the same cycles as the result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= '0;
    end else if (w_accept && !w_is_iter) begin
      r_flags <= w_flags_alu;
    end else if (w_iter_last) begin
      r_flags <= w_flags_iter;
    end
  end

  assign flags = r_flags;
`else
  assign flags = 4'b0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// Testbench for alu_seq (WIDTH=32): directed corner cases plus random
// operations, all compared against a behavioural arithmetic model.
module tb_alu_seq;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       flags;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .op        (op),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .flags     (flags)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference result from plain arithmetic on the operation definitions
  function automatic logic [31:0] ref_res(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    logic [63:0] e;
    logic [31:0] r;
    r = 32'h0;
    case (o)
      4'd0:  r = x + y;
      4'd1:  r = x - y;
      4'd2:  begin p = {32'h0, x} * {32'h0, y}; r = p[31:0]; end
      4'd3:  r = (y == 32'h0) ? 32'hFFFF_FFFF : x / y;
      4'd4:  r = x & y;
      4'd5:  r = x | y;
      4'd6:  r = x ^ y;
      4'd7:  r = ~x;
      4'd8:  r = x;
      4'd9:  r = y;
      4'd10: r = x << y[4:0];
      4'd11: r = x >> y[4:0];
      4'd12: begin e = {{32{x[31]}}, x} >> y[4:0]; r = e[31:0]; end
      4'd13: r = x + 32'd4;
      4'd14: r = x - 32'd4;
      default: r = 32'($countones(x));
    endcase
    return r;
  endfunction

  function automatic logic [3:0] ref_flags(input logic [3:0] o, input logic [31:0] x,
                                           input logic [31:0] y, input logic [31:0] r);
`ifdef ALU_SEQ_FLAGS_EN
    longint sx;
    longint sy;
    longint s;
    logic   c;
    logic   v;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    c  = 1'b0;
    v  = 1'b0;
    s  = 0;
    case (o)
      4'd0:  begin c = ({32'h0, x} + {32'h0, y}) > 64'hFFFF_FFFF; s = sx + sy; end
      4'd1:  begin c = (x < y);                                   s = sx - sy; end
      4'd13: begin c = (x > 32'hFFFF_FFFB);                       s = sx + 4;  end
      4'd14: begin c = (x < 32'd4);                               s = sx - 4;  end
      default: s = 0;
    endcase
    v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return {(r == 32'h0), r[31], c, v};
`else
    return 4'b0000;
`endif
  endfunction

  // Issue one request, wait for the result, hold it for 'hold' cycles, accept it
  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int hold);
    logic [31:0] er;
    logic [3:0]  ef;
    int          cnt;
    int          exp_lat;
    int          busy_ready;
    er      = ref_res(o, x, y);
    ef      = ref_flags(o, x, y, er);
    exp_lat = (o == 4'd2 || o == 4'd3) ? WIDTH : 0;
    check({tag, " ready_before"}, 64'(in_ready), 64'(1));
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    cnt = 0;
    busy_ready = 0;
    while (!out_valid && cnt < 200) begin
      if (in_ready) busy_ready++;
      in_valid = 1'b1; a = $urandom; b = $urandom; op = 4'($urandom);
      @(posedge clk); #1;
      cnt++;
    end
    check({tag, " latency"}, 64'(cnt), 64'(exp_lat));
    check({tag, " ready_while_busy"}, 64'(busy_ready), 64'(0));
    check({tag, " result"}, 64'(out), 64'(er));
    check({tag, " flags"}, 64'(flags), 64'(ef));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom; op = 4'($urandom);
      @(posedge clk); #1;
      check({tag, " hold"}, 64'({out_valid, out, flags}), 64'({1'b1, er, ef}));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " back_to_idle"}, 64'({in_ready, out_valid}), 64'(2'b10));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    logic [3:0]  ro;
    logic [31:0] rx;
    logic [31:0] ry;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 64'({in_ready, out_valid, out, flags}), 64'({1'b1, 1'b0, 32'h0, 4'h0}));
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add_wrap", 4'd0,  32'hFFFF_FFFF, 32'h1,         0);
    run_op("mul",      4'd2,  32'h0001_0000, 32'h0001_0003, 0);
    run_op("div",      4'd3,  32'd100,       32'd7,         1);
    run_op("div_by0",  4'd3,  32'h1234_5678, 32'h0,         0);
    run_op("sra",      4'd12, 32'h8000_0000, 32'h24,        0);
    run_op("popcnt",   4'd15, 32'hF0F0_000F, 32'h0,         5);
    run_op("sub_ovf",  4'd1,  32'h8000_0000, 32'h1,         0);
    run_op("dec_brw",  4'd14, 32'h2,         32'h0,         0);

    // Reset in the middle of a multiply: nothing may come out afterwards
    run_op("pre_rst",  4'd15, 32'h0000_00FF, 32'h0,         0);
    op = 4'd2; a = 32'h1234_5678; b = 32'h9ABC_DEF0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 64'({out_valid, in_ready, out, flags}), 64'({1'b0, 1'b1, 32'h0, 4'h0}));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_first_cycle", 64'({in_ready, out_valid}), 64'(2'b10));
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    check("rst_no_result", 64'(seen), 64'(0));
    run_op("post_rst_add", 4'd0, 32'h7FFF_FFFF, 32'h1, 0);

    for (int k = 0; k < 40; k++) begin
      ro = 4'($urandom_range(0, 15));
      rx = $urandom;
      ry = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if (ro == 4'd3 && $urandom_range(0, 4) == 0) ry = 32'h0;
      run_op($sformatf("rnd%0d_op%0d", k, ro), ro, rx, ry, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
